// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions used by the fetch stage: reset vector, stall-vector
// bit positions and the fetch-state encoding.
package if_stage_pkg;

   localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

   localparam int STALL_W    = 6;
   localparam int STALL_IF   = 0;
   localparam int STALL_ID   = 1;
   localparam int STALL_EX   = 2;
   localparam int STALL_MEM  = 3;
   localparam int STALL_WB   = 4;
   localparam int STALL_CTRL = 5;

   typedef enum logic [1:0] {
      FS_BOOT    = 2'd0,
      FS_RUN     = 2'd1,
      FS_HOLD_BR = 2'd2
   } fetch_state_e;

   // Instruction addresses are word aligned; low two bits are dropped.
   function automatic logic [63:0] align4(input logic [63:0] a);
      return a & ~64'h3;
   endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-SRAM read port between the fetch stage (master) and the SRAM (slave).
interface if_stage_if;
   logic        inst_sram_en;
   logic [63:0] inst_sram_addr;
   logic        inst_sram_ready;

   modport master (output inst_sram_en, output inst_sram_addr, input inst_sram_ready);
   modport slave  (input inst_sram_en, input inst_sram_addr, output inst_sram_ready);
endinterface

// File: rtl/if_stage_pc_redirect_buf.sv
// Holds a branch redirect that arrived while fetch was frozen and selects the
// next fetch PC when fetch advances.
module pc_redirect_buf
   import if_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_i,
   input  logic        advance_i,
   input  logic        br_e_i,
   input  logic [63:0] br_addr_i,
   input  logic [63:0] pc_i,
   output logic [63:0] next_pc_o,
   output logic        pending_o
);

   logic        pend_q, pend_d;
   logic [63:0] pend_addr_q, pend_addr_d;

   always_comb begin
      pend_d      = pend_q;
      pend_addr_d = pend_addr_q;
      if (advance_i) begin
         pend_d = 1'b0;
      end else if (valid_i && br_e_i) begin
         // A newer redirect replaces any older one still waiting.
         pend_d      = 1'b1;
         pend_addr_d = align4(br_addr_i);
      end
   end

   always_comb begin
      if (br_e_i)
         next_pc_o = align4(br_addr_i);
      else if (pend_q)
         next_pc_o = pend_addr_q;
      else
         next_pc_o = pc_i + 64'd4;
   end

   assign pending_o = pend_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q      <= 1'b0;
         pend_addr_q <= 64'd0;
      end else begin
         pend_q      <= pend_d;
         pend_addr_q <= pend_addr_d;
      end
   end

endmodule

// File: rtl/if_stage.sv
// RV64I instruction-fetch stage: PC generation, instruction-SRAM read issue,
// stall handling and deferred branch redirects.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               br_e,
   input  logic [63:0]        br_addr,
   if_stage_if.master         sram,
   output logic               pc_valid,
   output logic [63:0]        pc,
   output logic               stallreq_if,
   output logic [63:0]        fetch_cnt
);

   fetch_state_e state_q, state_d;
   logic [63:0]  pc_q, pc_d;
   logic         valid_q, valid_d;
   logic [63:0]  cnt_q, cnt_d;
   logic         advance;
   logic [63:0]  next_pc;
   logic         pending;
   logic         unused_sigs;

   // Only the PC-freeze bit matters here; the rest belong to later stages.
   assign unused_sigs = ^{stall[STALL_W-1:1], pending};

   assign sram.inst_sram_en   = valid_q & ~rst;
   assign sram.inst_sram_addr = {pc_q[63:3], 3'b000};
   assign stallreq_if         = sram.inst_sram_en & ~sram.inst_sram_ready;
   assign advance             = valid_q & ~stall[STALL_IF] & ~stallreq_if;

   pc_redirect_buf u_redirect (
      .clk       (clk),
      .rst       (rst),
      .valid_i   (valid_q),
      .advance_i (advance),
      .br_e_i    (br_e),
      .br_addr_i (br_addr),
      .pc_i      (pc_q),
      .next_pc_o (next_pc),
      .pending_o (pending)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      case (state_q)
         FS_BOOT: begin
            state_d = FS_RUN;
            pc_d    = RESET_PC;
            valid_d = 1'b1;
         end
         FS_RUN, FS_HOLD_BR: begin
            if (advance) begin
               pc_d    = next_pc;
               cnt_d   = cnt_q + 64'd1;
               state_d = FS_RUN;
            end else if (br_e) begin
               state_d = FS_HOLD_BR;
            end
         end
         default: begin
            state_d = FS_BOOT;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FS_BOOT;
         pc_q    <= RESET_PC;
         valid_q <= 1'b0;
         cnt_q   <= 64'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pc        = pc_q;
   assign pc_valid  = valid_q;
   assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Fetch-stage bench: directed scenarios with literal expectations, then random
// traffic compared every cycle against a behavioural model.
module tb_if_stage;

   localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  stall = 6'd0;
   logic        br_e = 1'b0;
   logic [63:0] br_addr = 64'd0;
   logic        pc_valid;
   logic [63:0] pc;
   logic        stallreq_if;
   logic [63:0] fetch_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   if_stage_if sram_if ();

   if_stage #(.RESET_PC(RPC)) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .br_e        (br_e),
      .br_addr     (br_addr),
      .sram        (sram_if),
      .pc_valid    (pc_valid),
      .pc          (pc),
      .stallreq_if (stallreq_if),
      .fetch_cnt   (fetch_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
      end
   endtask

   // Behavioural model: a fetch PC, a valid flag, an advance counter and at most
   // one remembered redirect target.
   logic [63:0] m_pc = RPC;
   logic        m_valid = 1'b0;
   logic [63:0] m_cnt = 64'd0;
   logic        m_has_pend = 1'b0;
   logic [63:0] m_pend = 64'd0;

   always @(posedge clk) begin
      if (rst) begin
         m_pc = RPC; m_valid = 1'b0; m_cnt = 64'd0; m_has_pend = 1'b0; m_pend = 64'd0;
      end else if (!m_valid) begin
         m_valid = 1'b1;
         m_pc    = RPC;
      end else if (!stall[0] && sram_if.inst_sram_ready) begin
         m_cnt = m_cnt + 1;
         if (br_e)            m_pc = {br_addr[63:2], 2'b00};
         else if (m_has_pend) m_pc = m_pend;
         else                 m_pc = m_pc + 4;
         m_has_pend = 1'b0;
      end else if (br_e) begin
         m_has_pend = 1'b1;
         m_pend     = {br_addr[63:2], 2'b00};
      end
   end

   always @(negedge clk) begin
      logic exp_en;
      exp_en = m_valid && !rst;
      chk("pc", pc, m_pc);
      chk("pc_valid", {63'd0, pc_valid}, {63'd0, m_valid});
      chk("fetch_cnt", fetch_cnt, m_cnt);
      chk("inst_sram_en", {63'd0, sram_if.inst_sram_en}, {63'd0, exp_en});
      chk("stallreq_if", {63'd0, stallreq_if}, {63'd0, exp_en && !sram_if.inst_sram_ready});
      if (exp_en) chk("inst_sram_addr", sram_if.inst_sram_addr, {m_pc[63:3], 3'b000});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      sram_if.inst_sram_ready = 1'b1;
      repeat (3) tick();
      chk("rst_valid", {63'd0, pc_valid}, 64'd0);
      chk("rst_en", {63'd0, sram_if.inst_sram_en}, 64'd0);
      chk("rst_cnt", fetch_cnt, 64'd0);
      chk("rst_pc", pc, 64'h8000_0000);
      rst = 1'b0;
      tick(); chk("boot_pc", pc, 64'h8000_0000); chk("boot_valid", {63'd0, pc_valid}, 64'd1);
      tick(); chk("seq_pc1", pc, 64'h8000_0004);
      tick(); chk("seq_pc2", pc, 64'h8000_0008); chk("seq_cnt2", fetch_cnt, 64'd2);

      sram_if.inst_sram_ready = 1'b0;
      #1 chk("nrdy_sr1", {63'd0, stallreq_if}, 64'd1);
      tick(); chk("nrdy_pc", pc, 64'h8000_0008); chk("nrdy_sr2", {63'd0, stallreq_if}, 64'd1);
      tick(); chk("nrdy_cnt", fetch_cnt, 64'd2);
      sram_if.inst_sram_ready = 1'b1;
      tick(); chk("rdy_pc", pc, 64'h8000_000C); chk("rdy_cnt", fetch_cnt, 64'd3);
      tick(); chk("pc10", pc, 64'h8000_0010);

      br_e = 1'b1; br_addr = 64'h8000_0103;
      tick(); br_e = 1'b0;
      chk("br_pc", pc, 64'h8000_0100); chk("br_addr", sram_if.inst_sram_addr, 64'h8000_0100);

      stall = 6'b000001;
      br_e = 1'b1; br_addr = 64'h8000_0200; tick(); chk("stl_pc1", pc, 64'h8000_0100);
      br_e = 1'b0;                           tick(); chk("stl_pc2", pc, 64'h8000_0100);
      br_e = 1'b1; br_addr = 64'h8000_0300; tick(); chk("stl_pc3", pc, 64'h8000_0100);
      br_e = 1'b0;                           tick(); chk("stl_pc4", pc, 64'h8000_0100);
      stall = 6'd0;
      tick(); chk("stl_rel_pc", pc, 64'h8000_0300); chk("stl_cnt", fetch_cnt, 64'd6);
      tick(); chk("stl_run_pc", pc, 64'h8000_0304);

      stall = 6'b000001; br_e = 1'b1; br_addr = 64'h8000_0400; tick();
      br_e = 1'b0; tick();
      stall = 6'd0; br_e = 1'b1; br_addr = 64'h8000_0500; tick();
      br_e = 1'b0; chk("hold_br_pc", pc, 64'h8000_0500);
      tick(); chk("hold_drop_pc", pc, 64'h8000_0504);

      stall = 6'b000001; br_e = 1'b1; br_addr = 64'h8000_0600; tick();
      rst = 1'b1; stall = 6'd0; br_e = 1'b0; tick();
      chk("hrst_pc", pc, 64'h8000_0000); chk("hrst_valid", {63'd0, pc_valid}, 64'd0);
      chk("hrst_cnt", fetch_cnt, 64'd0);
      rst = 1'b0; tick(); tick(); chk("hrst_nobr_pc", pc, 64'h8000_0004);

      br_e = 1'b1; br_addr = 64'hFFFF_FFFF_FFFF_FFFE; tick(); br_e = 1'b0;
      chk("wrap_top", pc, 64'hFFFF_FFFF_FFFF_FFFC);
      tick(); chk("wrap_zero", pc, 64'd0);

      for (int i = 0; i < 3000; i++) begin
         rst     = ($urandom_range(0, 99) == 0);
         stall   = 6'($urandom) & ~6'h1;
         stall[0] = ($urandom_range(0, 3) == 0);
         sram_if.inst_sram_ready = ($urandom_range(0, 3) != 0);
         br_e    = ($urandom_range(0, 4) == 0);
         br_addr = ($urandom_range(0, 9) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15)))
                                               : {$urandom, $urandom};
         tick();
      end
      rst = 1'b0; br_e = 1'b0; stall = 6'd0;
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
